l2_ctrl_arbiter: RTL

Sequencer and round-robin arbiter in front of the L2 cache array. It accepts line-granular read (L1 fill) and write (L1 writeback) requests from NUM_REQ requesters and serialises them onto the single-port L2 array. It performs tag compare, handles misses via a memory fetch-and-fill handshake, and returns responses. Top-level glue maps the arr_* ports onto the array's addr/valid/cacheline_update/cacheline_lookup; the valid bit maps to state != L2_I.

---
 rtl/l2_ctrl_arbiter_if.sv | 55 +++++
 rtl/l2_ctrl_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/l2_ctrl_arbiter_if.sv
// rtl/l2_ctrl_arbiter_if.sv - request, L2 array and memory signal bundle for l2_ctrl_arbiter
interface l2_ctrl_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 26,
  parameter int INDEX_W = 10,
  parameter int LINE_W  = 512
);
  localparam int TAG_W = ADDR_W - INDEX_W;

  // requester side
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*LINE_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [LINE_W-1:0]         resp_data;

  // L2 array side
  logic [ADDR_W-1:0]         arr_addr;
  logic                      arr_wr;
  logic                      arr_wr_vld;
  logic [TAG_W-1:0]          arr_wr_tag;
  logic [LINE_W-1:0]         arr_wr_data;
  logic                      arr_rd_vld;
  logic [TAG_W-1:0]          arr_rd_tag;
  logic [LINE_W-1:0]         arr_rd_data;

  // memory fetch side
  logic                      mem_req_valid;
  logic [ADDR_W-1:0]         mem_req_addr;
  logic                      mem_req_ready;
  logic                      mem_resp_valid;
  logic [LINE_W-1:0]         mem_resp_data;

  // arbiter view
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_data,
    output arr_addr, arr_wr, arr_wr_vld, arr_wr_tag, arr_wr_data,
    input  arr_rd_vld, arr_rd_tag, arr_rd_data,
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_resp_valid, mem_resp_data
  );

  // environment view: requesters, array and memory
  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_data,
    input  arr_addr, arr_wr, arr_wr_vld, arr_wr_tag, arr_wr_data,
    output arr_rd_vld, arr_rd_tag, arr_rd_data,
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_resp_valid, mem_resp_data
  );
endinterface

// File: rtl/l2_ctrl_arbiter.sv
// rtl/l2_ctrl_arbiter.sv - round-robin request sequencer in front of the single-port L2 array
module l2_ctrl_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 26,
  parameter int INDEX_W = 10,
  parameter int LINE_W  = 512
) (
  input  logic             clk,
  input  logic             reset,
  l2_ctrl_arbiter_if.slave bus
);
  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_MEM_REQ, S_MEM_WAIT, S_FILL, S_RESP
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ID_W-1:0]   r_ptr;
  logic [ID_W-1:0]   r_id;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic [LINE_W-1:0] r_resp_data;

  logic              w_any;
  logic [ID_W-1:0]   w_winner;
  logic [ID_W-1:0]   w_cand;
  logic [ID_W-1:0]   w_ptr_next;
  logic              w_hit;
  logic [TAG_W-1:0]  w_tag;

  // first requesting index at or after the pointer, wrapping; scan backwards so the closest wins
  always_comb begin
    w_any    = 1'b0;
    w_winner = r_ptr;
    w_cand   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_cand = ID_W'((int'(r_ptr) + k) % NUM_REQ);
      if (bus.req_valid[w_cand]) begin
        w_any    = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  assign w_ptr_next = (w_winner == ID_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
  assign w_tag      = r_addr[ADDR_W-1:INDEX_W];
  assign w_hit      = bus.arr_rd_vld && (bus.arr_rd_tag == w_tag);

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_any) w_next = S_LOOKUP;
      S_LOOKUP:   w_next = (r_write || w_hit) ? S_RESP : S_MEM_REQ;
      S_MEM_REQ:  if (bus.mem_req_ready) w_next = S_MEM_WAIT;
      S_MEM_WAIT: if (bus.mem_resp_valid) w_next = S_FILL;
      S_FILL:     w_next = S_RESP;
      S_RESP:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // transaction latch: grant payload, RR pointer and the line returned to the requester
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr       <= '0;
      r_id        <= '0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_resp_data <= '0;
    end else begin
      if (r_state == S_IDLE && w_any) begin
        r_id    <= w_winner;
        r_write <= bus.req_write[w_winner];
        r_addr  <= bus.req_addr[w_winner*ADDR_W +: ADDR_W];
        r_wdata <= bus.req_wdata[w_winner*LINE_W +: LINE_W];
        r_ptr   <= w_ptr_next;
      end
      if (r_state == S_LOOKUP && !r_write && w_hit) r_resp_data <= bus.arr_rd_data;
      if (r_state == S_MEM_WAIT && bus.mem_resp_valid) r_resp_data <= bus.mem_resp_data;
    end
  end

  // state-decoded strobes; the grant is masked during reset so a held request sees no pulse
  always_comb begin
    bus.req_ready     = '0;
    bus.resp_valid    = '0;
    bus.arr_wr        = 1'b0;
    bus.arr_wr_vld    = 1'b0;
    bus.arr_wr_tag    = '0;
    bus.arr_wr_data   = '0;
    bus.mem_req_valid = 1'b0;
    case (r_state)
      S_IDLE:    if (w_any && !reset) bus.req_ready[w_winner] = 1'b1;
      S_LOOKUP: begin
        if (r_write) begin
          bus.arr_wr      = 1'b1;
          bus.arr_wr_vld  = 1'b1;
          bus.arr_wr_tag  = w_tag;
          bus.arr_wr_data = r_wdata;
        end
      end
      S_MEM_REQ: bus.mem_req_valid = 1'b1;
      S_FILL: begin
        bus.arr_wr      = 1'b1;
        bus.arr_wr_vld  = 1'b1;
        bus.arr_wr_tag  = w_tag;
        bus.arr_wr_data = r_resp_data;
      end
      S_RESP:    bus.resp_valid[r_id] = 1'b1;
      default:   ;
    endcase
  end

  assign bus.arr_addr     = r_addr;
  assign bus.mem_req_addr = r_addr;
  assign bus.resp_data    = r_resp_data;
endmodule
